// File: rtl/hazard_stall_ctrl_if.sv
// Bundles the ID-stage hazard inputs and the stall/forward controls of hazard_stall_ctrl.
interface hazard_stall_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [5:0]       OpCode;
    logic [5:0]       Func;
    logic [REG_W-1:0] RegRS_IFID;
    logic [REG_W-1:0] RegRT_IFID;
    logic             UsesRS_ID;
    logic             UsesRT_ID;
    logic             RegWrite_IDEX;
    logic             MemRead_IDEX;
    logic [REG_W-1:0] RegDstNum_IDEX;
    logic             RegWrite_EXMEM;
    logic             MemRead_EXMEM;
    logic [REG_W-1:0] RegDstNum_EXMEM;
    logic             RegWrite_MEMWB;
    logic [REG_W-1:0] RegDstNum_MEMWB;
    logic             BranchTaken;
    logic             MemBusy;
    logic             DebugHalt;
    logic             CntClear;

    logic             PCWrite;
    logic             IFIDWrite;
    logic             ControlStall;
    logic             FlushIF;
    logic             PipeFreeze;
    logic [1:0]       ForwardCmpA;
    logic [1:0]       ForwardCmpB;
    logic             HaltAck;
    logic [CNT_W-1:0] StallCount;

    // Pipeline side: drives hazard inputs, consumes the controls
    modport master (
        output OpCode, Func, RegRS_IFID, RegRT_IFID, UsesRS_ID, UsesRT_ID,
               RegWrite_IDEX, MemRead_IDEX, RegDstNum_IDEX,
               RegWrite_EXMEM, MemRead_EXMEM, RegDstNum_EXMEM,
               RegWrite_MEMWB, RegDstNum_MEMWB,
               BranchTaken, MemBusy, DebugHalt, CntClear,
        input  PCWrite, IFIDWrite, ControlStall, FlushIF, PipeFreeze,
               ForwardCmpA, ForwardCmpB, HaltAck, StallCount
    );

    // Controller side
    modport slave (
        input  OpCode, Func, RegRS_IFID, RegRT_IFID, UsesRS_ID, UsesRT_ID,
               RegWrite_IDEX, MemRead_IDEX, RegDstNum_IDEX,
               RegWrite_EXMEM, MemRead_EXMEM, RegDstNum_EXMEM,
               RegWrite_MEMWB, RegDstNum_MEMWB,
               BranchTaken, MemBusy, DebugHalt, CntClear,
        output PCWrite, IFIDWrite, ControlStall, FlushIF, PipeFreeze,
               ForwardCmpA, ForwardCmpB, HaltAck, StallCount
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Hazard detection and stall controller beside the ID stage of a 5-stage MIPS pipeline:
// load-use and branch-operand stalls, IF flush, compare forwarding, memory freeze,
// debug halt and a saturating bubble counter.
module hazard_stall_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input logic                Clk,
    input logic                Reset,
    hazard_stall_ctrl_if.slave bus
);
    localparam logic [1:0]       RUN      = 2'd0;
    localparam logic [1:0]       LSTALL   = 2'd1;
    localparam logic [1:0]       BSTALL   = 2'd2;
    localparam logic [1:0]       HALT     = 2'd3;
    localparam logic [2:0]       LAT_M1   = 3'(LOAD_LAT - 1);
    localparam logic [REG_W-1:0] ZERO_REG = '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [2:0] bub;
    logic [2:0] bub_nxt;

    logic       use_a;
    logic       use_b;
    logic       a_idex;
    logic       b_idex;
    logic       a_exmem;
    logic       b_exmem;
    logic       a_memwb;
    logic       b_memwb;
    logic       is_jump;
    logic       is_jr;
    logic       is_br;
    logic       load_use;
    logic       br_dep;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    // Operand matches, control-transfer decode and hazard conditions
    always_comb begin
        use_a   = bus.UsesRS_ID && (bus.RegRS_IFID != ZERO_REG);
        use_b   = bus.UsesRT_ID && (bus.RegRT_IFID != ZERO_REG);
        a_idex  = bus.RegWrite_IDEX  && (bus.RegDstNum_IDEX  == bus.RegRS_IFID);
        b_idex  = bus.RegWrite_IDEX  && (bus.RegDstNum_IDEX  == bus.RegRT_IFID);
        a_exmem = bus.RegWrite_EXMEM && (bus.RegDstNum_EXMEM == bus.RegRS_IFID);
        b_exmem = bus.RegWrite_EXMEM && (bus.RegDstNum_EXMEM == bus.RegRT_IFID);
        a_memwb = bus.RegWrite_MEMWB && (bus.RegDstNum_MEMWB == bus.RegRS_IFID);
        b_memwb = bus.RegWrite_MEMWB && (bus.RegDstNum_MEMWB == bus.RegRT_IFID);

        is_jump = (bus.OpCode == 6'b000010) || (bus.OpCode == 6'b000011);
        is_jr   = (bus.OpCode == 6'b000000) &&
                  ((bus.Func == 6'b001000) || (bus.Func == 6'b001001));
        is_br   = (bus.OpCode == 6'b000100) || (bus.OpCode == 6'b000101) ||
                  (bus.OpCode == 6'b000110) || (bus.OpCode == 6'b000111) ||
                  (bus.OpCode == 6'b000001);

        load_use = bus.MemRead_IDEX && ((use_a && a_idex) || (use_b && b_idex));
        br_dep   = (is_br || is_jr) &&
                   ((use_a && (a_idex || (bus.MemRead_EXMEM && a_exmem))) ||
                    (use_b && (b_idex || (bus.MemRead_EXMEM && b_exmem))));

        // A load in EX/MEM has no ALU result yet, so it never forwards from there
        fwd_a = 2'b00;
        if (bus.RegRS_IFID != ZERO_REG) begin
            if (a_exmem && !bus.MemRead_EXMEM) fwd_a = 2'b01;
            else if (a_memwb)                  fwd_a = 2'b10;
        end
        fwd_b = 2'b00;
        if (bus.RegRT_IFID != ZERO_REG) begin
            if (b_exmem && !bus.MemRead_EXMEM) fwd_b = 2'b01;
            else if (b_memwb)                  fwd_b = 2'b10;
        end
    end

    // Next state and combinational control outputs, highest priority first
    always_comb begin
        state_nxt        = state;
        bub_nxt          = bub;
        bus.PCWrite      = 1'b1;
        bus.IFIDWrite    = 1'b1;
        bus.ControlStall = 1'b0;
        bus.FlushIF      = 1'b0;
        bus.PipeFreeze   = 1'b0;
        bus.HaltAck      = 1'b0;
        bus.ForwardCmpA  = 2'b00;
        bus.ForwardCmpB  = 2'b00;

        if (Reset) begin
            bus.PCWrite   = 1'b0;
            bus.IFIDWrite = 1'b0;
            state_nxt     = RUN;
            bub_nxt       = 3'd0;
        end else if (bus.MemBusy) begin
            bus.PipeFreeze = 1'b1;
            bus.PCWrite    = 1'b0;
            bus.IFIDWrite  = 1'b0;
        end else begin
            case (state)
                HALT: begin
                    bus.PipeFreeze = 1'b1;
                    bus.PCWrite    = 1'b0;
                    bus.IFIDWrite  = 1'b0;
                    bus.HaltAck    = 1'b1;
                    if (!bus.DebugHalt) state_nxt = RUN;
                end
                LSTALL: begin
                    bus.PCWrite      = 1'b0;
                    bus.IFIDWrite    = 1'b0;
                    bus.ControlStall = 1'b1;
                    bub_nxt          = bub - 3'd1;
                    if (bub <= 3'd1) state_nxt = RUN;
                end
                // BSTALL re-evaluates like RUN but cannot chain another BSTALL or enter HALT
                RUN, BSTALL: begin
                    if (load_use || br_dep) begin
                        bus.PCWrite      = 1'b0;
                        bus.IFIDWrite    = 1'b0;
                        bus.ControlStall = 1'b1;
                        if (load_use && (LOAD_LAT > 1)) begin
                            state_nxt = LSTALL;
                            bub_nxt   = LAT_M1;
                        end else if (br_dep && (state == RUN)) begin
                            state_nxt = BSTALL;
                        end else begin
                            state_nxt = RUN;
                        end
                    end else begin
                        bus.ForwardCmpA = fwd_a;
                        bus.ForwardCmpB = fwd_b;
                        bus.FlushIF     = is_jump || is_jr || (is_br && bus.BranchTaken);
                        state_nxt       = ((state == RUN) && bus.DebugHalt) ? HALT : RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State and remaining-bubble registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= RUN;
            bub   <= 3'd0;
        end else begin
            state <= state_nxt;
            bub   <= bub_nxt;
        end
    end

    // Saturating bubble counter; clear wins over increment
    always_ff @(posedge Clk) begin
        if (Reset || bus.CntClear) begin
            bus.StallCount <= '0;
        end else if (bus.ControlStall && (bus.StallCount != CNT_MAX)) begin
            bus.StallCount <= bus.StallCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (LOAD_LAT=2/CNT_W=16 and LOAD_LAT=3/CNT_W=4)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_hazard_stall_ctrl;
    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       rw_x;
        logic       mr_x;
        logic [4:0] d_x;
        logic       rw_m;
        logic       mr_m;
        logic [4:0] d_m;
        logic       rw_w;
        logic [4:0] d_w;
        logic       tk;
        logic       busy;
        logic       dbg;
        logic       clr;
    } in_t;

    typedef struct packed {
        logic       pcw;
        logic       ifw;
        logic       cs;
        logic       fl;
        logic       pf;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       ha;
    } mout_t;

    // Model state: halted flag, remaining load bubbles, branch retry pending, bubble count
    typedef struct packed {
        bit halted;
        int bleft;
        bit bretry;
        int cnt;
    } mst_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) i2 ();
    hazard_stall_ctrl_if #(.REG_W(5), .CNT_W(4))  i3 ();

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(2), .CNT_W(16)) dut2 (.Clk(Clk), .Reset(Reset), .bus(i2));
    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4))  dut3 (.Clk(Clk), .Reset(Reset), .bus(i3));

    int    n_chk  = 0;
    int    n_pass = 0;
    int    cyc    = 0;
    mst_t  m2     = '0;
    mst_t  m3     = '0;
    mout_t last2;
    mout_t last3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic logic [1:0] fwd_sel(input logic [4:0] r, input in_t v);
        if (r != 0 && v.rw_m && v.d_m == r && !v.mr_m) return 2'b01;
        if (r != 0 && v.rw_w && v.d_w == r)             return 2'b10;
        return 2'b00;
    endfunction

    // Behavioural reference: one cycle of expected outputs plus the next model state
    function automatic void model(input in_t v, input mst_t s, input int lat, input int cntw,
                                  output mout_t o, output mst_t n);
        int cmax = (1 << cntw) - 1;
        bit ua, ub, lu, dep, isbr, isjr, isj;
        n = s;
        o = '0;
        o.pcw = 1'b1;
        o.ifw = 1'b1;
        if (v.rst) begin
            o = '0;
            n = '0;
        end else begin
            if (v.busy) begin
                o.pf = 1'b1; o.pcw = 1'b0; o.ifw = 1'b0;
            end else if (s.halted) begin
                o.pf = 1'b1; o.pcw = 1'b0; o.ifw = 1'b0; o.ha = 1'b1;
                n.halted = v.dbg;
            end else if (s.bleft > 0) begin
                o.pcw = 1'b0; o.ifw = 1'b0; o.cs = 1'b1;
                n.bleft = s.bleft - 1;
            end else begin
                ua   = v.urs && v.rs != 0;
                ub   = v.urt && v.rt != 0;
                lu   = v.mr_x && v.rw_x && ((ua && v.d_x == v.rs) || (ub && v.d_x == v.rt));
                isbr = v.op inside {6'd4, 6'd5, 6'd6, 6'd7, 6'd1};
                isjr = v.op == 6'd0 && (v.fn == 6'd8 || v.fn == 6'd9);
                isj  = v.op == 6'd2 || v.op == 6'd3;
                dep  = (isbr || isjr) &&
                       ((ua && ((v.rw_x && v.d_x == v.rs) || (v.mr_m && v.rw_m && v.d_m == v.rs))) ||
                        (ub && ((v.rw_x && v.d_x == v.rt) || (v.mr_m && v.rw_m && v.d_m == v.rt))));
                if (lu || dep) begin
                    o.pcw = 1'b0; o.ifw = 1'b0; o.cs = 1'b1;
                    n.bretry = 1'b0;
                    if (lu && lat > 1)        n.bleft  = lat - 1;
                    else if (dep && !s.bretry) n.bretry = 1'b1;
                end else begin
                    o.fa = fwd_sel(v.rs, v);
                    o.fb = fwd_sel(v.rt, v);
                    o.fl = isj || isjr || (isbr && v.tk);
                    if (!s.bretry && v.dbg) n.halted = 1'b1;
                    n.bretry = 1'b0;
                end
            end
            if (v.clr)                    n.cnt = 0;
            else if (o.cs && s.cnt < cmax) n.cnt = s.cnt + 1;
            else                           n.cnt = s.cnt;
        end
    endfunction

    task automatic apply(input in_t v);
        Reset = v.rst;
        i2.OpCode = v.op;  i2.Func = v.fn;  i2.RegRS_IFID = v.rs;  i2.RegRT_IFID = v.rt;
        i2.UsesRS_ID = v.urs;  i2.UsesRT_ID = v.urt;
        i2.RegWrite_IDEX = v.rw_x;  i2.MemRead_IDEX = v.mr_x;  i2.RegDstNum_IDEX = v.d_x;
        i2.RegWrite_EXMEM = v.rw_m;  i2.MemRead_EXMEM = v.mr_m;  i2.RegDstNum_EXMEM = v.d_m;
        i2.RegWrite_MEMWB = v.rw_w;  i2.RegDstNum_MEMWB = v.d_w;
        i2.BranchTaken = v.tk;  i2.MemBusy = v.busy;  i2.DebugHalt = v.dbg;  i2.CntClear = v.clr;
        i3.OpCode = v.op;  i3.Func = v.fn;  i3.RegRS_IFID = v.rs;  i3.RegRT_IFID = v.rt;
        i3.UsesRS_ID = v.urs;  i3.UsesRT_ID = v.urt;
        i3.RegWrite_IDEX = v.rw_x;  i3.MemRead_IDEX = v.mr_x;  i3.RegDstNum_IDEX = v.d_x;
        i3.RegWrite_EXMEM = v.rw_m;  i3.MemRead_EXMEM = v.mr_m;  i3.RegDstNum_EXMEM = v.d_m;
        i3.RegWrite_MEMWB = v.rw_w;  i3.RegDstNum_MEMWB = v.d_w;
        i3.BranchTaken = v.tk;  i3.MemBusy = v.busy;  i3.DebugHalt = v.dbg;  i3.CntClear = v.clr;
    endtask

    function automatic mout_t obs2();
        mout_t o;
        o.pcw = i2.PCWrite;  o.ifw = i2.IFIDWrite;  o.cs = i2.ControlStall;  o.fl = i2.FlushIF;
        o.pf = i2.PipeFreeze;  o.fa = i2.ForwardCmpA;  o.fb = i2.ForwardCmpB;  o.ha = i2.HaltAck;
        return o;
    endfunction

    function automatic mout_t obs3();
        mout_t o;
        o.pcw = i3.PCWrite;  o.ifw = i3.IFIDWrite;  o.cs = i3.ControlStall;  o.fl = i3.FlushIF;
        o.pf = i3.PipeFreeze;  o.fa = i3.ForwardCmpA;  o.fb = i3.ForwardCmpB;  o.ha = i3.HaltAck;
        return o;
    endfunction

    task automatic cmp_out(input string p, input mout_t g, input mout_t e, input int gc, input int ec);
        check({p, ".PCWrite"},      32'(g.pcw), 32'(e.pcw));
        check({p, ".IFIDWrite"},    32'(g.ifw), 32'(e.ifw));
        check({p, ".ControlStall"}, 32'(g.cs),  32'(e.cs));
        check({p, ".FlushIF"},      32'(g.fl),  32'(e.fl));
        check({p, ".PipeFreeze"},   32'(g.pf),  32'(e.pf));
        check({p, ".ForwardCmpA"},  32'(g.fa),  32'(e.fa));
        check({p, ".ForwardCmpB"},  32'(g.fb),  32'(e.fb));
        check({p, ".HaltAck"},      32'(g.ha),  32'(e.ha));
        check({p, ".StallCount"},   32'(gc),    32'(ec));
    endtask

    // Drive one cycle, compare at the falling edge, advance the model at the rising edge
    task automatic step(input in_t v, input bit chk);
        mout_t e2, e3;
        mst_t  n2, n3;
        apply(v);
        #4;
        model(v, m2, 2, 16, e2, n2);
        model(v, m3, 3, 4, e3, n3);
        last2 = obs2();
        last3 = obs3();
        if (chk) begin
            cmp_out("lat2", last2, e2, int'(i2.StallCount), m2.cnt);
            cmp_out("lat3", last3, e3, int'(i3.StallCount), m3.cnt);
        end
        @(posedge Clk);
        #1;
        m2 = n2;
        m3 = n3;
        cyc++;
    endtask

    function automatic in_t nop_in(input logic [4:0] rs);
        in_t v = '0;
        v.op = 6'd0; v.fn = 6'd32; v.rs = rs; v.rt = 5'd10; v.urs = 1'b1; v.urt = 1'b1;
        return v;
    endfunction

    function automatic in_t ld_use_in(input logic [4:0] r);
        in_t v = nop_in(r);
        v.mr_x = 1'b1; v.rw_x = 1'b1; v.d_x = r;
        return v;
    endfunction

    function automatic in_t rnd_in();
        in_t v = '0;
        logic [5:0] ops [10] = '{6'd0, 6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd35};
        v.op   = ops[$urandom_range(0, 9)];
        v.fn   = ($urandom_range(0, 2) == 0) ? 6'd32 : 6'(8 + $urandom_range(0, 1));
        v.rs   = 5'($urandom_range(0, 3));
        v.rt   = 5'($urandom_range(0, 3));
        v.urs  = 1'($urandom_range(0, 1));
        v.urt  = 1'($urandom_range(0, 1));
        v.rw_x = 1'($urandom_range(0, 1));
        v.mr_x = ($urandom_range(0, 2) == 0);
        v.d_x  = 5'($urandom_range(0, 3));
        v.rw_m = 1'($urandom_range(0, 1));
        v.mr_m = ($urandom_range(0, 2) == 0);
        v.d_m  = 5'($urandom_range(0, 3));
        v.rw_w = 1'($urandom_range(0, 1));
        v.d_w  = 5'($urandom_range(0, 3));
        v.tk   = 1'($urandom_range(0, 1));
        v.busy = ($urandom_range(0, 7) == 0);
        v.dbg  = ($urandom_range(0, 6) == 0);
        v.clr  = ($urandom_range(0, 29) == 0);
        v.rst  = ($urandom_range(0, 59) == 0);
        return v;
    endfunction

    initial begin
        in_t v;
        apply(nop_in(5'd0));
        Reset = 1'b1;
        @(posedge Clk);
        #1;

        // Reset: first cycle primes the registers, second is checked
        v = '0; v.rst = 1'b1;
        step(v, 1'b0);
        step(v, 1'b1);
        check("reset_pcwrite", 32'(last2.pcw), 32'd0);

        // Load-use on r8: 2 bubbles at LOAD_LAT=2, 3 at LOAD_LAT=3
        step(ld_use_in(5'd8), 1'b1);
        check("lu_first_stall", 32'(last2.cs), 32'd1);
        for (int i = 0; i < 3; i++) step(nop_in(5'd8), 1'b1);
        check("lu_cnt_lat2", 32'(i2.StallCount), 32'd2);
        check("lu_cnt_lat3", 32'(i3.StallCount), 32'd3);

        // beq on rt=9 behind addi in EX: one bubble, then forward from EX/MEM
        v = '0; v.op = 6'd4; v.rs = 5'd3; v.rt = 5'd9; v.urs = 1'b1; v.urt = 1'b1;
        v.rw_x = 1'b1; v.d_x = 5'd9;
        step(v, 1'b1);
        check("br_dep_stall", 32'(last2.cs), 32'd1);
        v.rw_x = 1'b0; v.d_x = 5'd0; v.rw_m = 1'b1; v.d_m = 5'd9;
        step(v, 1'b1);
        check("br_retry_nostall", 32'(last2.cs), 32'd0);
        check("br_fwd_b", 32'(last2.fb), 32'd1);
        check("br_fwd_a", 32'(last2.fa), 32'd0);

        // Register 0 never matches; jal flushes
        v = nop_in(5'd0); v.rt = 5'd5; v.mr_x = 1'b1; v.rw_x = 1'b1; v.d_x = 5'd0;
        step(v, 1'b1);
        check("r0_nostall", 32'(last2.cs), 32'd0);
        v = '0; v.op = 6'd3;
        step(v, 1'b1);
        check("jal_flush", 32'(last2.fl), 32'd1);
        check("jal_pcwrite", 32'(last2.pcw), 32'd1);

        // MemBusy during the second bubble freezes without counting
        step(ld_use_in(5'd8), 1'b1);
        v = nop_in(5'd8); v.busy = 1'b1;
        step(v, 1'b1);
        check("busy_freeze", 32'(last3.pf), 32'd1);
        check("busy_nostall", 32'(last3.cs), 32'd0);
        for (int i = 0; i < 3; i++) step(nop_in(5'd8), 1'b1);
        check("busy_cnt_lat3", 32'(i3.StallCount), 32'd7);
        check("busy_cnt_lat2", 32'(i2.StallCount), 32'd5);

        // Debug halt handshake
        v = nop_in(5'd1); v.dbg = 1'b1;
        step(v, 1'b1);
        check("halt_req_noack", 32'(last2.ha), 32'd0);
        step(v, 1'b1);
        check("halt_ack", 32'(last2.ha), 32'd1);
        check("halt_freeze", 32'(last2.pf), 32'd1);
        step(nop_in(5'd1), 1'b1);
        check("halt_release_ack", 32'(last2.ha), 32'd1);
        step(nop_in(5'd1), 1'b1);
        check("halt_exit", 32'(last2.ha), 32'd0);

        // Reset during LSTALL aborts the remaining bubbles
        step(ld_use_in(5'd8), 1'b1);
        v = '0; v.rst = 1'b1;
        step(v, 1'b1);
        check("rst_cnt", 32'(i2.StallCount), 32'd0);
        step(nop_in(5'd8), 1'b1);
        check("rst_abort", 32'(last2.cs), 32'd0);

        // Counter saturation at CNT_W=4, then clear beats a simultaneous stall
        for (int i = 0; i < 20; i++) step(ld_use_in(5'd8), 1'b1);
        check("sat_lat3", 32'(i3.StallCount), 32'd15);
        check("nosat_lat2", 32'(i2.StallCount), 32'd20);
        v = ld_use_in(5'd8); v.clr = 1'b1;
        step(v, 1'b1);
        check("clr_lat3", 32'(i3.StallCount), 32'd0);
        check("clr_lat2", 32'(i2.StallCount), 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) step(rnd_in(), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised, stateful hazard detection and stall controller for the 5-stage MIPS pipeline. It sits beside the ID stage.
- It generates the PC, IF/ID and ID/EX bubble controls, IF flushes, and branch-compare forwarding selects.
- It adds the following:
  - multi-cycle load-use stalls (configurable load latency),
  - memory-wait global freeze,
  - debug halt handshake,
  - a saturating stall-cycle counter.

Parameters:
REG_W, 5, register-number width
LOAD_LAT, 1, load-use bubbles inserted per hazard (1..7)
CNT_W, 16, stall counter width

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
OpCode  in  6  ID-stage opcode
Func  in  6  ID-stage function field
RegRS_IFID  in  REG_W  ID rs
RegRT_IFID  in  REG_W  ID rt
UsesRS_ID  in  1  ID instruction reads rs (from decoder)
UsesRT_ID  in  1  ID instruction reads rt
RegWrite_IDEX  in  1  EX instruction writes a register
MemRead_IDEX  in  1  EX instruction is a load
RegDstNum_IDEX  in  REG_W  resolved EX destination register (rt, rd or 31)
RegWrite_EXMEM  in  1  MEM instruction writes a register
MemRead_EXMEM  in  1  MEM instruction is a load
RegDstNum_EXMEM  in  REG_W  MEM destination register
RegWrite_MEMWB  in  1  WB instruction writes a register
RegDstNum_MEMWB  in  REG_W  WB destination register
BranchTaken  in  1  ID comparator result (valid for branches)
MemBusy  in  1  data/instruction memory not ready
DebugHalt  in  1  halt request from the debug unit
CntClear  in  1  clear the stall counter
PCWrite  out  1  PC update enable
IFIDWrite  out  1  IF/ID register update enable
ControlStall  out  1  insert a bubble into ID/EX (zero the controls)
FlushIF  out  1  squash the IF/ID contents
PipeFreeze  out  1  hold every pipeline register
ForwardCmpA  out  2  rs compare source: 00 regfile, 01 EX/MEM ALU, 10 MEM/WB
ForwardCmpB  out  2  rt compare source, same encoding
HaltAck  out  1  pipeline is halted
StallCount  out  CNT_W  cumulative bubble cycles

Behaviour:
- States: RUN, LSTALL, BSTALL, HALT. The state register and the remaining-bubble counter (3 bits) are clocked.
- Outputs are combinational from state and inputs, except StallCount, which is registered.
- Register 0 never matches: any comparison with register number 0 is false.
- Match definitions:
  - useA = UsesRS_ID and rs≠0.
  - useB = UsesRT_ID and rt≠0.
  - matchX(r) = RegWrite_X and RegDstNum_X==r.
- Control-transfer decode (internal):
  - J: 000010.
  - JAL: 000011.
  - JR/JALR: 000000 with Func 001000 or 001001.
  - Branch: 000100, 000101, 000110, 000111, 000001.
- Default outputs: PCWrite=1, IFIDWrite=1, ControlStall=0, FlushIF=0, PipeFreeze=0, HaltAck=0, Fwd=00.
- Priority, highest first: Reset > MemBusy > HALT > LSTALL/BSTALL > new detection.
- Reset:
  - state=RUN, counter=0, StallCount=0.
  - Outputs during the reset cycle: PCWrite=0, IFIDWrite=0, all other outputs 0.
  - Reset in any state aborts that state with no residual bubbles.
- MemBusy=1:
  - PipeFreeze=1, PCWrite=0, IFIDWrite=0, ControlStall=0.
  - State and bubble counter hold; StallCount does not increment.
- Load-use hazard (RUN):
  - Condition: MemRead_IDEX and (useA or useB) matches RegDstNum_IDEX.
  - Outputs: PCWrite=0, IFIDWrite=0, ControlStall=1.
  - If LOAD_LAT>1: go to LSTALL with counter=LOAD_LAT-1.
- LSTALL:
  - Same stall outputs; counter decrements each unfrozen cycle.
  - At counter==1 the next state is RUN.
  - Total bubbles per hazard = LOAD_LAT.
- Branch/JR dependency (RUN), for branch or JR/JALR:
  - Condition: an operand matches the EX writer (matchIDEX), or matches a load in MEM (MemRead_EXMEM and matchEXMEM).
  - Action: stall outputs as for load-use, and go to BSTALL.
  - BSTALL lasts one cycle, then RUN. The dependency is then re-evaluated, so a load in EX yields 2 bubbles total.
- Forwarding select (when not stalling):
  - ForwardCmpA=01 if matchEXMEM(rs) and not MemRead_EXMEM.
  - Else 10 if matchMEMWB(rs).
  - Else 00.
  - ForwardCmpB: same rule for rt.
- Flush:
  - Condition: J, JAL, JR/JALR, or a branch with BranchTaken, in RUN and not stalled.
  - Outputs: FlushIF=1, PCWrite=1, IFIDWrite=1.
  - Stall takes priority over flush in the same cycle.
- Debug halt:
  - Entry: DebugHalt=1 in RUN with no hazard detected → HALT next cycle. A request arriving during LSTALL/BSTALL is honoured on return to RUN.
  - In HALT: PipeFreeze=1, PCWrite=0, IFIDWrite=0, HaltAck=1.
  - Exit: DebugHalt=0 → RUN next cycle, HaltAck=0.
- StallCount:
  - +1 on every cycle with ControlStall=1.
  - Saturates at 2^CNT_W-1.
  - CntClear zeroes it; CntClear wins over a simultaneous increment.

Test Plan:
- LOAD_LAT=2; EX: lw, RegDstNum_IDEX=8; ID: add with rs=8 → ControlStall=1 and PCWrite=0 for exactly 2 cycles, then RUN; StallCount=2.
- EX: addi writing 9; ID: beq with rt=9 → 1 bubble. Next cycle, with EX/MEM writing 9 (not a load) → ForwardCmpB=01, ForwardCmpA=00.
- ID: add with rs=0; EX: lw writing 0 → no stall; ID: jal → FlushIF=1, PCWrite=1.
- LOAD_LAT=3 load-use with MemBusy=1 on the 2nd bubble cycle → PipeFreeze=1, ControlStall=0, counter holds; total bubbles still 3.
- DebugHalt=1 in RUN → HaltAck=1 on the next cycle, PipeFreeze=1; release → HaltAck=0 one cycle later. Reset during LSTALL → RUN, StallCount=0.
- CNT_W=4; 20 consecutive load-use stalls → StallCount saturates at 15. CntClear asserted together with a stall → StallCount=0.
